// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding an 8-entry show-ahead FIFO.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | line idle, waiting for a falling edge on rx_s
// S_START | timing to mid start bit; a high resample there is a glitch
// S_DATA  | sampling 8 data bits LSB first, one per bit period
// S_STOP  | timing to mid stop bit; high pushes the byte, low is a framing error
// S_BREAK | line stuck low after a framing error, wait for it to go high
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH_LOG2   = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx,
    input  logic                  rd_en,
    output logic [7:0]            data_out,
    output logic                  data_valid,
    output logic                  fifo_full,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  frame_err,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [CNT_W-1:0]      HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]      FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_DEPTH = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   OCC_ONE = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PT_ONE = DEPTH_LOG2'(1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t                r_state;
    logic                  r_rx_meta;
    logic                  r_rx_s;
    logic [CNT_W-1:0]      r_baud_cnt;
    logic [2:0]            r_bit_idx;
    logic [7:0]            r_shift;
    logic                  r_frame_err;

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_pt;
    logic [DEPTH_LOG2-1:0] r_rd_pt;
    logic [DEPTH_LOG2:0]   r_count;
    logic [7:0]            r_data_out;
    logic                  r_overflow;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_do_push;
    logic                  w_head_is_new;
    logic [DEPTH_LOG2:0]   w_count_nxt;
    logic [DEPTH_LOG2-1:0] w_rd_pt_nxt;

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // A good stop bit hands the assembled byte to the FIFO in the same cycle.
    assign w_push = (r_state == S_STOP) && (r_baud_cnt == FULL_M1) && r_rx_s;

    // Receive FSM with baud counter; counter restarts on every state change.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_baud_cnt  <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_baud_cnt <= '0;
                    if (!r_rx_s) r_state <= S_START;
                end
                S_START: begin
                    if (r_baud_cnt == HALF_M1) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_state    <= r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (r_baud_cnt == FULL_M1) begin
                        r_baud_cnt <= '0;
                        r_shift    <= {r_rx_s, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) r_state <= S_STOP;
                        else                   r_bit_idx <= r_bit_idx + 3'd1;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (r_baud_cnt == FULL_M1) begin
                        r_baud_cnt <= '0;
                        if (r_rx_s) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_ONE;
                    end
                end
                S_BREAK: begin
                    r_baud_cnt <= '0;
                    if (r_rx_s) r_state <= S_IDLE;
                end
                default: begin
                    r_baud_cnt <= '0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO next-state: a pop frees a slot, so push-while-full succeeds with it.
    always_comb begin
        w_pop         = rd_en && (r_count != '0);
        w_do_push     = w_push && ((r_count != CNT_DEPTH) || w_pop);
        w_count_nxt   = r_count;
        if (w_do_push && !w_pop)      w_count_nxt = r_count + OCC_ONE;
        else if (!w_do_push && w_pop) w_count_nxt = r_count - OCC_ONE;
        w_rd_pt_nxt   = w_pop ? (r_rd_pt + PT_ONE) : r_rd_pt;
        // Pushed byte becomes the head only if nothing else remains after the pop.
        w_head_is_new = w_do_push && ((r_count == '0) || ((r_count == OCC_ONE) && w_pop));
    end

    // Storage array; contents are don't-care until the occupancy says otherwise.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_pt] <= r_shift;
    end

    // Pointers, occupancy, registered show-ahead head and overflow pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_pt    <= '0;
            r_rd_pt    <= '0;
            r_count    <= '0;
            r_data_out <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_push && !w_do_push;
            r_count    <= w_count_nxt;
            r_rd_pt    <= w_rd_pt_nxt;
            if (w_do_push) r_wr_pt <= r_wr_pt + PT_ONE;
            if (w_count_nxt != '0)
                r_data_out <= w_head_is_new ? r_shift : r_mem[w_rd_pt_nxt];
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = (r_count != '0);
    assign fifo_full  = (r_count == CNT_DEPTH);
    assign fifo_count = r_count;
    assign frame_err  = r_frame_err;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit.
module tb_uart_rx_fifo;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       fifo_full;
    logic [3:0] fifo_count;
    logic       frame_err;
    logic       overflow;

    int checks = 0;
    int failures = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(3)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rx         (rx),
        .rd_en      (rd_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Pulse counters; each one-cycle pulse is seen at exactly one rising edge.
    always @(posedge clk) begin
        if (frame_err) fe_cnt++;
        if (overflow)  ov_cnt++;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_push;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_head(input logic [7:0] b);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
    endtask

    task automatic send_stop(input logic s);
        rx = s;
        tick(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_head(b);
        send_stop(1'b1);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    initial begin
        int fe0;
        int ov0;
        int bad;

        vecs[0] = '{data: 8'h5A, stop: 1'b1, exp_push: 1'b1};
        vecs[1] = '{data: 8'h00, stop: 1'b1, exp_push: 1'b1};
        vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_push: 1'b1};
        vecs[3] = '{data: 8'h3C, stop: 1'b0, exp_push: 1'b0};
        vecs[4] = '{data: 8'h81, stop: 1'b1, exp_push: 1'b1};
        vecs[5] = '{data: 8'h96, stop: 1'b0, exp_push: 1'b0};

        // Reset and idle
        tick(5);
        chk("rst_data_out", {24'h0, data_out}, 32'h0);
        chk("rst_flags", {26'h0, data_valid, fifo_full, frame_err, overflow, 2'b00}, 32'h0);
        chk("rst_count", {28'h0, fifo_count}, 32'h0);
        rstn = 1'b1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (data_valid) bad++;
        end
        chk("idle_valid", bad, 0);

        // Single byte with exact arrival cycle
        send_head(8'hA5);
        rx = 1'b1;
        tick(10);
        chk("a5_valid_early", {31'h0, data_valid}, 32'h0);
        tick(1);
        chk("a5_valid_on_time", {31'h0, data_valid}, 32'h1);
        chk("a5_data", {24'h0, data_out}, 32'hA5);
        chk("a5_count", {28'h0, fifo_count}, 32'h1);
        tick(5);
        pop();
        chk("a5_pop_valid", {31'h0, data_valid}, 32'h0);
        chk("a5_pop_count", {28'h0, fifo_count}, 32'h0);

        // Glitch on the line
        fe0 = fe_cnt;
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(40);
        chk("glitch_count", {28'h0, fifo_count}, 32'h0);
        chk("glitch_fe", fe_cnt - fe0, 0);

        // Table of frames, good and bad stop bits
        for (int v = 0; v < 6; v++) begin
            fe0 = fe_cnt;
            send_head(vecs[v].data);
            if (vecs[v].stop) begin
                send_stop(1'b1);
            end else begin
                send_stop(1'b0);
                tick(100);
                rx = 1'b1;
                tick(20);
            end
            tick(2);
            chk($sformatf("vec%0d_count", v), {28'h0, fifo_count}, {31'h0, vecs[v].exp_push});
            chk($sformatf("vec%0d_fe", v), fe_cnt - fe0, vecs[v].exp_push ? 0 : 1);
            if (vecs[v].exp_push) begin
                chk($sformatf("vec%0d_data", v), {24'h0, data_out}, {24'h0, vecs[v].data});
                pop();
                chk($sformatf("vec%0d_empty", v), {31'h0, data_valid}, 32'h0);
            end
        end

        // Fill, then overflow on the ninth byte
        for (int i = 0; i < 8; i++) send_byte(8'(i));
        chk("fill_full", {31'h0, fifo_full}, 32'h1);
        chk("fill_count", {28'h0, fifo_count}, 32'h8);
        ov0 = ov_cnt;
        send_byte(8'h08);
        tick(2);
        chk("ovf_pulse", ov_cnt - ov0, 1);
        chk("ovf_count", {28'h0, fifo_count}, 32'h8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d", i), {24'h0, data_out}, i);
            pop();
        end
        chk("drain_empty", {31'h0, data_valid}, 32'h0);

        // Push and pop in the same cycle while full
        for (int i = 0; i < 8; i++) send_byte(8'h60 + 8'(i));
        ov0 = ov_cnt;
        send_head(8'h55);
        rx = 1'b1;
        tick(10);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        tick(5);
        chk("sim_ovf", ov_cnt - ov0, 0);
        chk("sim_count", {28'h0, fifo_count}, 32'h8);
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("sim_drain%0d", i), {24'h0, data_out}, 32'h60 + i);
            pop();
        end
        chk("sim_last", {24'h0, data_out}, 32'h55);
        pop();
        chk("sim_empty", {31'h0, data_valid}, 32'h0);

        // Streaming with pointer wrap
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            send_byte(8'h10 + 8'(i));
            if (data_out !== 8'h10 + 8'(i) || fifo_count !== 4'd1) bad++;
            pop();
        end
        chk("wrap_errors", bad, 0);
        chk("wrap_empty", {28'h0, fifo_count}, 32'h0);

        // Async reset mid-frame
        send_byte(8'h9A);
        rx = 1'b0;
        tick(CPB * 4);
        rstn = 1'b0;
        rx = 1'b1;
        tick(3);
        chk("mrst_count", {28'h0, fifo_count}, 32'h0);
        chk("mrst_valid", {31'h0, data_valid}, 32'h0);
        chk("mrst_data", {24'h0, data_out}, 32'h0);
        rstn = 1'b1;
        tick(20);
        send_byte(8'hC3);
        tick(2);
        chk("post_rst_data", {24'h0, data_out}, 32'hC3);
        chk("post_rst_count", {28'h0, fifo_count}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
